// File: rtl/fetch_f_stage_if.sv
// rtl/fetch_f_stage_if.sv - instruction-memory read channel between fetch stage and memory
// Signals:
//   imem_req_o    request, held with imem_addr_o until the ack cycle
//   imem_addr_o   8-byte-aligned doubleword address
//   imem_ack_i    read complete; imem_rdata_i and imem_err_i valid this cycle
//   imem_rdata_i  little-endian doubleword
//   imem_err_i    address error, qualified by imem_ack_i
interface fetch_f_stage_if;
   logic        imem_req_o;
   logic [63:0] imem_addr_o;
   logic        imem_ack_i;
   logic [63:0] imem_rdata_i;
   logic        imem_err_i;

   modport master (
      output imem_req_o, imem_addr_o,
      input  imem_ack_i, imem_rdata_i, imem_err_i
   );

   modport slave (
      input  imem_req_o, imem_addr_o,
      output imem_ack_i, imem_rdata_i, imem_err_i
   );
endinterface

// File: rtl/fetch_f_stage.sv
// rtl/fetch_f_stage.sv - Y86-64 fetch stage assembling instructions from aligned doubleword reads
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   F_stall_i               hold the presented instruction and PC
//   redirect_i, _pc_i       PC correction, wins over every other transition
//   imem (master)           one outstanding aligned read at a time
//   f_stat_o .. f_valP_o    decoded instruction for the F/D register (bubble when not valid)
//   f_valid_o               f_* outputs hold a complete instruction
module fetch_f_stage #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   F_stall_i,
   input  logic                   redirect_i,
   input  logic [63:0]            redirect_pc_i,
   fetch_f_stage_if.master        imem,
   output logic [2:0]             f_stat_o,
   output logic [63:0]            f_pc_o,
   output logic [3:0]             f_icode_o,
   output logic [3:0]             f_ifun_o,
   output logic [3:0]             f_rA_o,
   output logic [3:0]             f_rB_o,
   output logic [63:0]            f_valC_o,
   output logic [63:0]            f_valP_o,
   output logic                   f_valid_o
);
   localparam logic [2:0] SAOK = 3'd1;
   localparam logic [2:0] SHLT = 3'd2;
   localparam logic [2:0] SADR = 3'd3;
   localparam logic [2:0] SINS = 3'd4;

   typedef enum logic [1:0] {REQ_LO, REQ_HI, VALID, HALTED} state_e;

   state_e      state_q, state_d;
   logic [63:0] pc_q, pc_d, addr_q, lo_q, hi_q;
   logic        drop_q, err_q;

   function automatic logic need_regs(input logic [3:0] ic);
      case (ic)
         4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: need_regs = 1'b1;
         default:                                  need_regs = 1'b0;
      endcase
   endfunction

   function automatic logic need_valc(input logic [3:0] ic);
      case (ic)
         4'h3, 4'h4, 4'h5, 4'h7, 4'h8: need_valc = 1'b1;
         default:                      need_valc = 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] ins_len(input logic [3:0] ic);
      ins_len = 4'd1 + {3'b000, need_regs(ic)} + {need_valc(ic), 3'b000};
   endfunction

   // The opcode byte always sits in the low word, so the low ack alone
   // decides whether a second read is needed.
   logic [3:0] lo_icode;
   logic       lo_spans;
   assign lo_icode = imem.imem_rdata_i[{pc_q[2:0], 3'b100} +: 4];
   assign lo_spans = (5'(pc_q[2:0]) + 5'(ins_len(lo_icode))) > 5'd8;

   logic busy, take, new_req;
   assign busy    = (state_q == REQ_LO) || (state_q == REQ_HI);
   // An ack is kept only if no redirect is pending or arriving with it.
   assign take    = busy && imem.imem_ack_i && !drop_q && !redirect_i;
   assign new_req = (state_d == REQ_LO) && ((state_q != REQ_LO) || imem.imem_ack_i);

   // Decode of the 16-byte buffer starting at the PC byte offset.
   logic [79:0] win;
   logic [3:0]  raw_icode, dec_icode, dec_ifun, dec_ra, dec_rb, dec_len;
   logic        has_regs, has_valc, dec_bad;
   logic [2:0]  dec_stat;
   logic [63:0] dec_valc, dec_valp;

   always_comb begin
      win       = 80'({hi_q, lo_q} >> {pc_q[2:0], 3'b000});
      raw_icode = win[7:4];
      has_regs  = need_regs(raw_icode);
      has_valc  = need_valc(raw_icode);
      dec_bad   = err_q || (raw_icode > 4'hB);
      if (err_q)                   dec_stat = SADR;
      else if (raw_icode > 4'hB)   dec_stat = SINS;
      else if (raw_icode == 4'h0)  dec_stat = SHLT;
      else                         dec_stat = SAOK;
      dec_icode = raw_icode;
      dec_ifun  = win[3:0];
      dec_ra    = has_regs ? win[15:12] : 4'hF;
      dec_rb    = has_regs ? win[11:8]  : 4'hF;
      dec_valc  = !has_valc ? 64'h0 : (has_regs ? win[79:16] : win[71:8]);
      dec_len   = ins_len(raw_icode);
      if (dec_bad) begin
         dec_icode = 4'h1;
         dec_ifun  = 4'h0;
         dec_ra    = 4'hF;
         dec_rb    = 4'hF;
         dec_valc  = 64'h0;
         dec_len   = 4'd1;
      end
      dec_valp = pc_q + {60'h0, dec_len};
   end

   always_comb begin
      pc_d = pc_q;
      if (redirect_i)
         pc_d = redirect_pc_i;
      else if ((state_q == VALID) && !F_stall_i && (dec_stat == SAOK))
         pc_d = ((dec_icode == 4'h7) || (dec_icode == 4'h8)) ? dec_valc : dec_valp;
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= REQ_LO;
      else       state_q <= state_d;
   end

   // Next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         REQ_LO:
            if (imem.imem_ack_i) begin
               if (drop_q || redirect_i)                     state_d = REQ_LO;
               else if (imem.imem_err_i || !lo_spans)        state_d = VALID;
               else                                          state_d = REQ_HI;
            end
         REQ_HI:
            if (imem.imem_ack_i)
               state_d = (drop_q || redirect_i) ? REQ_LO : VALID;
         VALID:
            if (redirect_i)      state_d = REQ_LO;
            else if (!F_stall_i) state_d = (dec_stat == SAOK) ? REQ_LO : HALTED;
         HALTED:
            if (redirect_i)      state_d = REQ_LO;
         default:                state_d = REQ_LO;
      endcase
   end

   // Datapath: PC, request address, word buffer, drop and error flags
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q   <= RESET_PC;
         addr_q <= {RESET_PC[63:3], 3'b000};
         lo_q   <= 64'h0;
         hi_q   <= 64'h0;
         drop_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         pc_q <= pc_d;
         if (take && (state_q == REQ_LO)) begin
            lo_q  <= imem.imem_rdata_i;
            err_q <= imem.imem_err_i;
         end
         if (take && (state_q == REQ_HI)) begin
            hi_q  <= imem.imem_rdata_i;
            err_q <= imem.imem_err_i;
         end
         if (new_req) begin
            addr_q <= {pc_d[63:3], 3'b000};
            err_q  <= 1'b0;
            drop_q <= 1'b0;
         end else if ((state_q == REQ_LO) && (state_d == REQ_HI)) begin
            addr_q <= addr_q + 64'd8;
         end else if (busy && !imem.imem_ack_i && redirect_i) begin
            // Address must stay put until the ack; remember to discard it.
            drop_q <= 1'b1;
         end
      end
   end

   // Outputs
   always_comb begin
      imem.imem_req_o  = busy;
      imem.imem_addr_o = addr_q;
      f_valid_o = 1'b0;
      f_stat_o  = 3'd0;
      f_pc_o    = 64'h0;
      f_icode_o = 4'h1;
      f_ifun_o  = 4'h0;
      f_rA_o    = 4'hF;
      f_rB_o    = 4'hF;
      f_valC_o  = 64'h0;
      f_valP_o  = 64'h0;
      if (state_q == VALID) begin
         f_valid_o = 1'b1;
         f_stat_o  = dec_stat;
         f_pc_o    = pc_q;
         f_icode_o = dec_icode;
         f_ifun_o  = dec_ifun;
         f_rA_o    = dec_ra;
         f_rB_o    = dec_rb;
         f_valC_o  = dec_valc;
         f_valP_o  = dec_valp;
      end
   end
endmodule

// File: doc/fetch_f_stage.md
FETCH_F_STAGE -- requirements
Module: fetch_f_stage

Interface
REQ-001 Parameter: RESET_PC, 64'h0, PC loaded on reset.
REQ-002 Port: clk_i  in  1  clock; all state updates on rising edge.
REQ-003 Port: rst_i  in  1  reset, synchronous and active-high.
REQ-004 Port: F_stall_i  in  1  hold the presented instruction and PC.
REQ-005 Port: redirect_i  in  1  mispredict/ret correction.
REQ-006 Port: redirect_pc_i  in  64  corrected PC.
REQ-007 Port: imem_req_o  out  1  instruction-memory read request.
REQ-008 Port: imem_addr_o  out  64  8-byte-aligned read address.
REQ-009 Port: imem_ack_i  in  1  read complete; data and error valid this cycle.
REQ-010 Port: imem_rdata_i  in  64  little-endian doubleword.
REQ-011 Port: imem_err_i  in  1  address error, qualified by imem_ack_i.
REQ-012 Ports: f_stat_o (3), f_pc_o (64), f_icode_o (4), f_ifun_o (4), f_rA_o (4), f_rB_o (4), f_valC_o (64), f_valP_o (64), all out, feeding the F/D pipe register.
REQ-013 Port: f_valid_o  out  1  f_* outputs hold a complete instruction.

Function
REQ-014 FSM states: REQ_LO, REQ_HI, VALID, HALTED.
REQ-015 REQ_LO: req=1, addr={pc[63:3],3'b0}; on ack store lo word; go to REQ_HI if pc[2:0]+len>8, else VALID.
REQ-016 REQ_HI: req=1, addr=lo address+8; on ack store hi word; go to VALID.
REQ-017 imem_req_o and imem_addr_o stay constant from assertion until the ack cycle; at most one request outstanding.
REQ-018 Byte k of the instruction = byte (pc[2:0]+k) of the 16-byte buffer {hi,lo}.
REQ-019 Byte0 = {icode[7:4], ifun[3:0]}; regs byte {rA,rB} present for icode 2,3,4,5,6,A,B; valC present for icode 3,4,5,7,8.
REQ-020 valC = 8 little-endian bytes starting at byte1 (7,8) or byte2 (3,4,5); otherwise 0; absent register fields = 4'hF.
REQ-021 len = 1 + needRegs + 8*needValC; f_valP_o = pc + len, 64-bit wrap.
REQ-022 Status: SAOK=1, SHLT=2 (icode 0), SADR=3 (err on either ack), SINS=4 (icode > B).
REQ-023 SADR or SINS: icode=1 (NOP), ifun=0, rA=rB=F, valC=0, len=1; SADR takes precedence over SINS; err on lo ack skips REQ_HI.
REQ-024 f_valid_o=1 only in VALID; outside VALID, f_* outputs are bubble values: stat=0, pc=0, icode=1, ifun=0, rA=rB=F, valC=0, valP=0.
REQ-025 VALID with F_stall_i=1: all state and outputs held.
REQ-026 VALID with F_stall_i=0: pc <= valC for icode 7 or 8, else valP; go to REQ_LO; with stat SHLT/SADR/SINS go to HALTED instead, pc unchanged.
REQ-027 HALTED: no requests, f_valid_o=0, until redirect.
REQ-028 redirect_i has priority over F_stall_i and all other transitions: pc <= redirect_pc_i.
REQ-029 Redirect with no request outstanding, including in VALID and HALTED: next state REQ_LO.
REQ-030 Redirect while a request is outstanding: set a drop flag and keep the request until ack; discard the acked data and err, then REQ_LO at the new pc; a later redirect overwrites pc.
REQ-031 Latency: aligned single-word instruction, ack in the first request cycle -> f_valid_o one cycle later.

Reset
REQ-032 rst_i=1 at an edge: pc=RESET_PC, state=REQ_LO, drop flag=0, buffer=0; outputs are bubble values; rst_i overrides redirect_i and ack.
REQ-033 Any ack arriving during or after reset for a pre-reset request is ignored; imem_req_o=1 at RESET_PC in the first cycle after reset.

Verification
REQ-034 pc=0, mem[0]=30 F2 0A 00 00 00 00 00 00 00 (irmovq $10,%rdx) -> two reads (0,8); valid: icode=3, ifun=0, rA=F, rB=2, valC=10, valP=0x0A, stat=1.
REQ-035 pc=0x6, bytes 70 20 00 00 00 00 00 00 00 (jmp 0x20) -> reads 0x0, 0x8; valC=0x20, valP=0xF; on consume, next request at addr 0x20.
REQ-036 pc=0x0, byte 0xC0 -> stat=4, icode=1, valP=1; after consume, HALTED with imem_req_o=0; redirect_pc_i=0x40 -> request at 0x40.
REQ-037 REQ_LO ack with imem_err_i=1 -> stat=3, single read only; byte 0x00 (halt) -> stat=2, HALTED after consume.
REQ-038 Redirect to 0x100 two cycles before a delayed ack -> addr unchanged until ack, data discarded, next request at 0x100, f_valid_o stays 0 throughout.
REQ-039 Stall 3 cycles in VALID -> outputs constant, no request; rst_i mid-REQ_HI -> next cycle request at RESET_PC, f_valid_o=0.
